// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-shot and auto-reload modes and a one-cycle done pulse.
// Optional prescaler enabled by defining DCNT_PRESCALE_EN (PRESCALE enabled cycles per decrement).
module down_counter #(
  parameter int CNTR_WIDTH = 4,
  parameter int PRESCALE   = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [CNTR_WIDTH-1:0] load_val,
  input  logic                  auto,
  input  logic                  stop,
  input  logic                  en,
  output logic [CNTR_WIDTH-1:0] cnt,
  output logic                  zero,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_q;
  logic [CNTR_WIDTH-1:0]   cnt_q;
  logic [CNTR_WIDTH-1:0]   reload_q;
  logic                    auto_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    tick;

`ifdef DCNT_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // A tick is the enabled cycle that wraps the prescaler back to zero.
  assign tick = en && (pre_q == PW'(PRESCALE - 1));

  always_comb begin
    pre_d = pre_q;
    if (load || stop || state_q == IDLE) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  // Every enable is a tick; the comparison folds to constant true.
  assign tick = en && (PRESCALE >= 0);
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        cnt_q    <= load_val;
        reload_q <= load_val;
        auto_q   <= auto;
        if (load_val != '0) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end else if (state_q == RUN) begin
        if (stop) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (tick) begin
          // Terminal tick: reload in auto mode so cnt never reads zero there.
          if (cnt_q == CNTR_WIDTH'(1)) begin
            done_q <= 1'b1;
            if (auto_q) begin
              cnt_q <= reload_q;
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      end
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: tick-counting reference model plus directed literal checks.
`ifdef DCNT_PRESCALE_EN
  `define TB_LIT(n, c, b, d)
`else
  `define TB_LIT(n, c, b, d) lit(n, c, b, d);
`endif

module tb_down_counter;
  localparam int W = 4;
`ifdef DCNT_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic         clk = 1'b0;
  logic         clr, load, auto, stop, en;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt;
  logic         zero, busy, done;

  int checks = 0;
  int errors = 0;

  down_counter #(.CNTR_WIDTH(W), .PRESCALE(4)) dut (
    .clk(clk), .clr(clr), .load(load), .load_val(load_val), .auto(auto),
    .stop(stop), .en(en), .cnt(cnt), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: tracks enabled cycles since the last load and derives the
  // count from the number of completed ticks, rather than stepping a register.
  bit m_valid = 1'b0;
  bit m_run, m_auto, m_done;
  int m_n, m_ens, m_hold;

  function automatic int m_cnt();
    int ticks;
    ticks = m_ens / P;
    if (!m_run) return m_hold;
    if (m_auto) return m_n - (ticks % m_n);
    return m_n - ticks;
  endfunction

  always @(posedge clk) begin
    int ticks;
    m_done = 1'b0;
    if (clr) begin
      m_valid = 1'b1; m_run = 1'b0; m_hold = 0; m_auto = 1'b0; m_n = 0; m_ens = 0;
    end else if (load) begin
      m_n = int'(load_val); m_ens = 0; m_auto = auto;
      m_run = (load_val != 0); m_hold = int'(load_val);
    end else if (m_run && stop) begin
      m_hold = m_cnt(); m_run = 1'b0;
    end else if (m_run && en) begin
      m_ens++;
      if (m_ens % P == 0) begin
        ticks = m_ens / P;
        if (m_auto ? (ticks % m_n == 0) : (ticks == m_n)) m_done = 1'b1;
        if (!m_auto && ticks == m_n) begin
          m_run = 1'b0; m_hold = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (cnt !== W'(m_cnt()) || busy !== m_run || done !== m_done || zero !== (m_cnt() == 0)) begin
        errors++;
        $display("FAIL model t=%0t cnt=%0d busy=%0b done=%0b zero=%0b exp cnt=%0d busy=%0b done=%0b zero=%0b",
                 $time, cnt, busy, done, zero, m_cnt(), m_run, m_done, m_cnt() == 0);
      end
    end
  end

  task automatic cyc(input bit c, input bit l, input int lv, input bit a, input bit s, input bit e);
    clr = c; load = l; load_val = W'(lv); auto = a; stop = s; en = e;
    @(posedge clk);
    #1;
    $display("txn clr=%0b load=%0b lv=%0d auto=%0b stop=%0b en=%0b -> cnt=%0d busy=%0b done=%0b zero=%0b",
             c, l, lv, a, s, e, cnt, busy, done, zero);
  endtask

  task automatic lit(input string nm, input int c, input bit b, input bit d);
    checks++;
    if (cnt !== W'(c) || busy !== b || done !== d || zero !== (c == 0)) begin
      errors++;
      $display("FAIL %s got cnt=%0d busy=%0b done=%0b zero=%0b exp cnt=%0d busy=%0b done=%0b zero=%0b",
               nm, cnt, busy, done, zero, c, b, d, c == 0);
    end
  endtask

  initial begin
    int dcount;
    clr = 1'b1; load = 1'b0; load_val = '0; auto = 1'b0; stop = 1'b0; en = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    // Activity, then two cycles of clear.
    cyc(0, 1, 7, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 9, 0, 0, 1);
    lit("reset", 0, 0, 0);

    // One-shot count of 3.
    cyc(0, 1, 3, 0, 0, 0); `TB_LIT("os_load", 3, 1, 0)
    cyc(0, 0, 0, 0, 0, 1); `TB_LIT("os_2", 2, 1, 0)
    cyc(0, 0, 0, 0, 0, 1); `TB_LIT("os_1", 1, 1, 0)
    cyc(0, 0, 0, 0, 0, 1); `TB_LIT("os_done", 0, 0, 1)
    cyc(0, 0, 0, 0, 0, 1); `TB_LIT("os_hold", 0, 0, 0)

    // Auto-reload of 2.
    cyc(0, 1, 2, 1, 0, 0); `TB_LIT("ar_load", 2, 1, 0)
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      dcount += int'(done);
      `TB_LIT("ar_step", (i % 2 == 0) ? 1 : 2, 1, (i % 2 == 1))
    end
`ifndef DCNT_PRESCALE_EN
    checks++;
    if (dcount != 3) begin
      errors++;
      $display("FAIL ar_pulses got %0d exp 3", dcount);
    end
`endif

    // Restart mid-count, then stop.
    cyc(0, 1, 4, 0, 0, 0); `TB_LIT("rs_load", 4, 1, 0)
    cyc(0, 0, 0, 0, 0, 1); `TB_LIT("rs_3", 3, 1, 0)
    cyc(0, 0, 0, 0, 0, 1); `TB_LIT("rs_2", 2, 1, 0)
    cyc(0, 1, 5, 0, 0, 1); `TB_LIT("rs_reload", 5, 1, 0)
    cyc(0, 0, 0, 0, 1, 0); `TB_LIT("stop", 5, 0, 0)
    cyc(0, 0, 0, 0, 0, 1); `TB_LIT("stop_en", 5, 0, 0)

    // Load beats stop and a terminal en; zero load returns to idle.
    cyc(0, 1, 2, 0, 0, 0); `TB_LIT("pr_load", 2, 1, 0)
    cyc(0, 0, 0, 0, 0, 1); `TB_LIT("pr_1", 1, 1, 0)
    cyc(0, 1, 9, 0, 1, 1); `TB_LIT("pr_win", 9, 1, 0)
    cyc(0, 1, 0, 0, 0, 1); `TB_LIT("ld_zero", 0, 0, 0)

    // Full-range count from 15.
    cyc(0, 1, 15, 0, 0, 0); `TB_LIT("max_load", 15, 1, 0)
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      `TB_LIT("max_step", 15 - i, (i < 15), (i == 15))
    end

    // Clear at a terminal tick suppresses done.
    cyc(0, 1, 1, 0, 0, 0); `TB_LIT("clr_load", 1, 1, 0)
    cyc(1, 0, 0, 0, 0, 1); `TB_LIT("clr_run", 0, 0, 0)

    // Auto-reload of 1 pulses on every tick; stop wins over en.
    cyc(0, 1, 1, 1, 0, 0); `TB_LIT("ar1_load", 1, 1, 0)
    cyc(0, 0, 0, 0, 0, 1); `TB_LIT("ar1_a", 1, 1, 1)
    cyc(0, 0, 0, 0, 0, 1); `TB_LIT("ar1_b", 1, 1, 1)
    cyc(0, 0, 0, 0, 1, 1); `TB_LIT("ar1_stop", 1, 0, 0)

`ifdef DCNT_PRESCALE_EN
    cyc(0, 1, 2, 0, 0, 0); lit("ps_load", 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); lit("ps_e1", 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); lit("ps_e2", 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 0); lit("ps_stall", 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); lit("ps_e3", 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); lit("ps_e4", 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); lit("ps_e5", 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); lit("ps_e6", 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); lit("ps_e7", 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1); lit("ps_e8", 0, 0, 1);
`endif

    // Mixed traffic, checked only against the model.
    for (int i = 0; i < 120; i++) begin
      cyc(($urandom % 50) == 0, ($urandom % 10) == 0, int'($urandom_range(0, 15)),
          $urandom % 2 == 1, ($urandom % 16) == 0, ($urandom % 4) != 0);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down-counter/timer: the count-down counterpart to the team's 4-bit up-counter.
- Loads a start value, decrements on enable, and flags terminal count with a one-cycle `done` pulse.
- Supports one-shot and auto-reload operation.
- Sits beside the up-counter in timing/sequencing logic: the up-counter measures intervals, this block generates them.

Parameters:
- CNTR_WIDTH, 4: width of count, load value and reload value.
- PRESCALE, 4: enabled cycles per decrement; only used when DCNT_PRESCALE_EN is defined; legal range 2..256.

Ports:
- clk  input  1  posedge clock.
- clr  input  1  reset: synchronous, active-high; returns the block to its reset state.
- load  input  1  start/restart: captures load_val into cnt and into the reload register.
- load_val  input  CNTR_WIDTH  start value; sampled only when load=1.
- auto  input  1  mode, sampled with load: 1 = auto-reload, 0 = one-shot.
- stop  input  1  abort: go to IDLE and hold cnt.
- en  input  1  decrement enable (tick).
- cnt  output  CNTR_WIDTH  current count, registered.
- zero  output  1  combinational, high when cnt == 0.
- busy  output  1  registered, high in RUN.
- done  output  1  registered one-cycle pulse at terminal count.

Behaviour:
- Reset values (clr=1 at a posedge): cnt=0, reload register=0, mode=one-shot, busy=0, done=0, state=IDLE, prescaler=0.
- Priority at each posedge: clr > load > stop > en.
- Every action below takes effect at the posedge where it is sampled; outputs change 1 cycle after the sampling edge.
- done defaults to 0 every cycle unless a rule below sets it.
- States: IDLE (busy=0), RUN (busy=1). Stored state (cnt, reload register, mode, prescaler) changes only via the rules below.
- IDLE:
  - load=1, load_val != 0: cnt <= load_val; reload register <= load_val; mode <= auto; go to RUN.
  - load=1, load_val == 0: cnt <= 0; remain IDLE; no done pulse.
  - en ignored; cnt holds.
- RUN with load=1: restart. cnt, reload register and mode are re-captured as in IDLE.
  - If load_val == 0, go to IDLE.
  - No done pulse, even if a terminal en coincides.
- RUN with stop=1 (and load=0): go to IDLE; cnt holds its current value; no done pulse.
- RUN with en=1 and cnt > 1: cnt <= cnt - 1.
- RUN with en=1 and cnt == 1 (terminal tick): done <= 1 for exactly one cycle.
  - One-shot: cnt <= 0; go to IDLE.
  - Auto-reload: cnt <= reload register; remain in RUN. cnt never reads 0 in auto mode.
- Arithmetic: unsigned, CNTR_WIDTH bits.
  - Decrement is never applied at cnt == 0, so there is no underflow or wrap.
  - Maximum load is 2^CNTR_WIDTH - 1.
- Terminal latency: after a load of N, a continuous en produces done high in the cycle where cnt first reads 0 (one-shot), exactly N cycles after the load edge.
- clr while in RUN: immediate return to reset values; any pending done is suppressed.

Optional Feature:
- Macro: DCNT_PRESCALE_EN.
- Defined:
  - A prescaler counter of width clog2(PRESCALE) advances on each en while in RUN.
  - A decrement/terminal tick occurs only on the en that wraps the prescaler from PRESCALE-1 to 0.
  - The prescaler clears on clr, load, stop and entry to IDLE.
  - Effective period = N*PRESCALE enabled cycles.
- Not defined: every en in RUN is a tick; PRESCALE is unused; no prescaler logic is synthesized.

Test Plan:
- Reset: clr=1 for 2 cycles after arbitrary activity -> cnt=0, busy=0, done=0, zero=1.
- One-shot count: load=1, load_val=3, auto=0, then en=1 continuously -> cnt 3,2,1,0; done=1 only in the cycle cnt reads 0; busy falls with it; cnt holds at 0 afterwards.
- Auto-reload: load_val=2, auto=1, en=1 for 6 cycles -> cnt 2,1,2,1,2,1; done pulses on each 1->2 reload (3 pulses); busy stays 1.
- Restart and stop:
  - load_val=4, two ens -> cnt=2; then load_val=5 -> cnt=5, no done.
  - Then stop=1 -> busy=0, cnt holds 5; further en leaves cnt unchanged.
- Priority and edge cases:
  - load, stop and en all high at cnt=1 -> load wins; cnt=load_val, no done.
  - load_val=0 -> cnt=0, busy=0, no done.
  - load_val=15 (CNTR_WIDTH=4) counts down fully with no wrap.
- Prescale (DCNT_PRESCALE_EN, PRESCALE=4): load_val=2, en=1 continuously -> cnt 2 for 4 cycles, 1 for 4 cycles, then 0 with done on the 8th en; toggling en low stalls the prescaler.
